alu_2: RTL and testbench
========================

# alu_2

Single-cycle MIPS-I integer ALU with an integrated HI/LO register pair, used in the execute stage of the MIPS CPU. It decodes the instruction's opcode and function fields directly and produces a combinational 32-bit result plus a branch-taken flag. MULT/MULTU/DIV/DIVU/MTHI/MTLO update HI/LO on the clock edge.

## Interface
One clock; reset is asynchronous and active-low.
- clk  input  1  rising-edge clock for HI/LO
- rst_n  input  1  asynchronous active-low reset
- opcode  input  6  instr[31:26]
- functcode  input  6  instr[5:0]; decoded only when opcode = 0x00
- shamt  input  5  instr[10:6]
- immediate  input  16  instr[15:0]
- rs_content  input  32  rs register value
- rt_content  input  32  rt register value
- ALU_result  output  32  combinational result
- sig_branch  output  1  branch condition true (combinational)
- HI  output  32  HI register (registered)
- LO  output  32  LO register (registered)

## Operation
- opcode takes priority: functcode is ignored unless opcode = 0x00.
- R-type (opcode 0x00), keyed by functcode:
  - SLL 0x00, SRL 0x02, SRA 0x03: shift rt by shamt.
  - SLLV 0x04, SRLV 0x06, SRAV 0x07: shift rt by rs[4:0].
  - SRA/SRAV replicate rt[31].
  - ADDU 0x21, ADD 0x20: rs+rt. SUBU 0x23, SUB 0x22: rs−rt. No overflow trap.
  - AND 0x24, OR 0x25, XOR 0x26, NOR 0x27.
  - SLT 0x2A: signed compare. SLTU 0x2B: unsigned compare. Result is 1 or 0.
  - MFHI 0x10, MFLO 0x12: result = HI or LO (current registered value).
  - MTHI 0x11, MTLO 0x13: load rs into HI or LO at the next edge.
  - MULT 0x18 (signed) and MULTU 0x19 (unsigned): {HI,LO} ← full 64-bit product at the next edge.
  - DIV 0x1A (signed) and DIVU 0x1B (unsigned): LO ← quotient, HI ← remainder, at the next edge.
  - Signed DIV truncates toward zero; the remainder takes the sign of the dividend.
  - For MULT/MULTU/DIV/DIVU/MTHI/MTLO, ALU_result = 0.
  - JR 0x08 and JALR 0x09: result = rs.
  - Any other functcode: result 0, no HI/LO write.
- I-type, keyed by opcode:
  - BEQ 0x04: result = rs−rt; sig_branch = (rs == rt).
  - BNE 0x05: result = rs−rt; sig_branch = (rs != rt).
  - BLEZ 0x06: sig_branch = signed rs ≤ 0. BGTZ 0x07: sig_branch = signed rs > 0. Result 0.
  - ADDI 0x08, ADDIU 0x09: rs + sext(imm).
  - SLTI 0x0A: signed rs < sext(imm). SLTIU 0x0B: unsigned rs < sext(imm).
  - ANDI 0x0C, ORI 0x0D, XORI 0x0E: zero-extended imm.
  - LUI 0x0F: {imm, 16'h0}.
  - Loads/stores 0x20–0x2E: effective address rs + sext(imm).
  - Any other opcode: result 0.
- sig_branch = 0 for every non-branch opcode.
- Divide by zero (rt = 0, DIV or DIVU): HI and LO are left unchanged.
- Signed DIV of 0x80000000 by −1: LO = 0x80000000, HI = 0.

## Timing
- ALU_result and sig_branch are purely combinational from the inputs and the current HI/LO; they are valid in the same cycle.
- HI/LO are updated on the rising clk edge at which a write-class instruction is presented.
  - Latency is 1 edge.
  - An MFHI or MFLO in that same cycle returns the old value.
- A write instruction held for N edges rewrites the same value N times.
- rst_n low asynchronously forces HI = LO = 0, regardless of clk. Release is sampled at the next edge.
- There is no stall or enable input: every edge with a write-class instruction commits it.

## Structure
- Package alu_2_pkg holds:
  - opcode localparams (OP_RTYPE, OP_BEQ, OP_LUI, …)
  - funct localparams (FN_SLL … FN_SLTU)
- Sub-module alu_2_muldiv is purely combinational. From rs, rt and a signed/unsigned select it produces:
  - the 64-bit product
  - the 32-bit quotient and remainder
  - a div-by-zero flag
- The top level holds the result mux, branch compare and HI/LO registers.

## Test plan
- Reset, then MULT rs = 0xFFFFFFFC, rt = 0xFFFFFFFB, 1 edge -> HI = 0x00000000, LO = 0x00000014. MULTU 0x0088888A × 0x0088888B -> HI = 0x000048D1, LO = 0x5BFB72EE.
- DIV −7 / 5 (0xFFFFFFF9, 0x5) -> HI = 0xFFFFFFFE, LO = 0xFFFFFFFF. DIVU 0x0088888A / 0x0008888B -> HI = 0x00088865, LO = 0x0000000F. DIV with rt = 0 -> HI/LO unchanged.
- Shift and compare:
  - SRA shamt = 4, rt = 0xCA000000 -> 0xFCA00000.
  - SRL shamt = 4, rt = 0x4A -> 0x4.
  - SLTU rs = 0x0088888A, rt = 0x0088888B -> 1.
  - SLT rs = 0xFFFFFFFC, rt = 0x14 -> 1.
- Branches with rs = rt = 0x0088888A:
  - BEQ -> result 0, sig_branch = 1.
  - BNE -> sig_branch = 0.
  - BNE with rt = 0x0088888B -> sig_branch = 1.
- Immediate operations:
  - LUI imm = 0x888A -> 0x888A0000.
  - LW rs = 0x888A, imm = 0x0008 -> 0x00008892.
  - LW imm = 0xFFFC -> 0x00008886.
- Reset and HI/LO hazards:
  - MTHI 0x1234, then MFHI in the same cycle -> old HI; after the edge -> 0x1234.
  - Assert rst_n low mid-cycle -> HI = LO = 0 immediately.

Source files
------------

// File: rtl/alu_2_pkg.sv
// Opcode and function-field constants for the MIPS-I execute-stage ALU.
package alu_2_pkg;

  // Primary opcodes (instr[31:26])
  localparam logic [5:0] OP_RTYPE  = 6'h00;
  localparam logic [5:0] OP_BEQ    = 6'h04;
  localparam logic [5:0] OP_BNE    = 6'h05;
  localparam logic [5:0] OP_BLEZ   = 6'h06;
  localparam logic [5:0] OP_BGTZ   = 6'h07;
  localparam logic [5:0] OP_ADDI   = 6'h08;
  localparam logic [5:0] OP_ADDIU  = 6'h09;
  localparam logic [5:0] OP_SLTI   = 6'h0A;
  localparam logic [5:0] OP_SLTIU  = 6'h0B;
  localparam logic [5:0] OP_ANDI   = 6'h0C;
  localparam logic [5:0] OP_ORI    = 6'h0D;
  localparam logic [5:0] OP_XORI   = 6'h0E;
  localparam logic [5:0] OP_LUI    = 6'h0F;
  // Loads and stores occupy this contiguous range; all compute rs + sext(imm)
  localparam logic [5:0] OP_MEM_LO = 6'h20;
  localparam logic [5:0] OP_MEM_HI = 6'h2E;

  // Function codes (instr[5:0]) for R-type
  localparam logic [5:0] FN_SLL   = 6'h00;
  localparam logic [5:0] FN_SRL   = 6'h02;
  localparam logic [5:0] FN_SRA   = 6'h03;
  localparam logic [5:0] FN_SLLV  = 6'h04;
  localparam logic [5:0] FN_SRLV  = 6'h06;
  localparam logic [5:0] FN_SRAV  = 6'h07;
  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] FN_JALR  = 6'h09;
  localparam logic [5:0] FN_MFHI  = 6'h10;
  localparam logic [5:0] FN_MTHI  = 6'h11;
  localparam logic [5:0] FN_MFLO  = 6'h12;
  localparam logic [5:0] FN_MTLO  = 6'h13;
  localparam logic [5:0] FN_MULT  = 6'h18;
  localparam logic [5:0] FN_MULTU = 6'h19;
  localparam logic [5:0] FN_DIV   = 6'h1A;
  localparam logic [5:0] FN_DIVU  = 6'h1B;
  localparam logic [5:0] FN_ADD   = 6'h20;
  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_SUB   = 6'h22;
  localparam logic [5:0] FN_SUBU  = 6'h23;
  localparam logic [5:0] FN_AND   = 6'h24;
  localparam logic [5:0] FN_OR    = 6'h25;
  localparam logic [5:0] FN_XOR   = 6'h26;
  localparam logic [5:0] FN_NOR   = 6'h27;
  localparam logic [5:0] FN_SLT   = 6'h2A;
  localparam logic [5:0] FN_SLTU  = 6'h2B;

endpackage

// File: rtl/alu_2_muldiv.sv
// Combinational multiply/divide datapath feeding the HI/LO pair.
// Signed division is done on magnitudes and the signs are reapplied, which
// gives truncation toward zero, a dividend-signed remainder, and makes
// 0x80000000 / -1 fall out naturally as quotient 0x80000000, remainder 0.
module alu_2_muldiv
  import alu_2_pkg::*;
(
  input  logic [31:0] rs,
  input  logic [31:0] rt,
  input  logic        is_signed,
  output logic [63:0] product,
  output logic [31:0] quotient,
  output logic [31:0] remainder,
  output logic        div_by_zero
);

  logic [63:0] rs_ext;
  logic [63:0] rt_ext;
  logic        rs_neg;
  logic        rt_neg;
  logic [31:0] rs_mag;
  logic [31:0] rt_mag;
  logic [31:0] divisor;
  logic [31:0] q_mag;
  logic [31:0] r_mag;

  // Full 64-bit product: sign- or zero-extend, keep the low 64 bits
  always_comb begin
    rs_ext  = is_signed ? {{32{rs[31]}}, rs} : {32'h0, rs};
    rt_ext  = is_signed ? {{32{rt[31]}}, rt} : {32'h0, rt};
    product = rs_ext * rt_ext;
  end

  // Magnitude division with sign restoration; divisor forced nonzero so the
  // divider never sees zero (the result is discarded in that case anyway)
  always_comb begin
    div_by_zero = (rt == 32'h0);
    rs_neg      = is_signed & rs[31];
    rt_neg      = is_signed & rt[31];
    rs_mag      = rs_neg ? (32'h0 - rs) : rs;
    rt_mag      = rt_neg ? (32'h0 - rt) : rt;
    divisor     = div_by_zero ? 32'h1 : rt_mag;
    q_mag       = rs_mag / divisor;
    r_mag       = rs_mag % divisor;
    quotient    = (rs_neg ^ rt_neg) ? (32'h0 - q_mag) : q_mag;
    remainder   = rs_neg ? (32'h0 - r_mag) : r_mag;
  end

endmodule

// File: rtl/alu_2.sv
// MIPS-I execute-stage ALU: combinational result/branch decode plus the
// HI/LO register pair written by MULT/MULTU/DIV/DIVU/MTHI/MTLO.
module alu_2
  import alu_2_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [5:0]  opcode,
  input  logic [5:0]  functcode,
  input  logic [4:0]  shamt,
  input  logic [15:0] immediate,
  input  logic [31:0] rs_content,
  input  logic [31:0] rt_content,
  output logic [31:0] ALU_result,
  output logic        sig_branch,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  logic [31:0] hi_reg;
  logic [31:0] lo_reg;
  logic [31:0] hi_next;
  logic [31:0] lo_next;
  logic        hi_we;
  logic        lo_we;

  logic [31:0] imm_sext;
  logic [31:0] imm_zext;
  logic        md_signed;
  logic [63:0] md_product;
  logic [31:0] md_quotient;
  logic [31:0] md_remainder;
  logic        md_div_by_zero;

  assign imm_sext  = {{16{immediate[15]}}, immediate};
  assign imm_zext  = {16'h0, immediate};
  assign md_signed = (functcode == FN_MULT) || (functcode == FN_DIV);

  alu_2_muldiv u_muldiv (
    .rs          (rs_content),
    .rt          (rt_content),
    .is_signed   (md_signed),
    .product     (md_product),
    .quotient    (md_quotient),
    .remainder   (md_remainder),
    .div_by_zero (md_div_by_zero)
  );

  // Result mux and branch condition; opcode decode takes priority over funct
  always_comb begin
    ALU_result = 32'h0;
    sig_branch = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        case (functcode)
          FN_SLL:            ALU_result = rt_content << shamt;
          FN_SRL:            ALU_result = rt_content >> shamt;
          FN_SRA:            ALU_result = $signed(rt_content) >>> shamt;
          FN_SLLV:           ALU_result = rt_content << rs_content[4:0];
          FN_SRLV:           ALU_result = rt_content >> rs_content[4:0];
          FN_SRAV:           ALU_result = $signed(rt_content) >>> rs_content[4:0];
          FN_JR, FN_JALR:    ALU_result = rs_content;
          FN_MFHI:           ALU_result = hi_reg;
          FN_MFLO:           ALU_result = lo_reg;
          FN_ADD, FN_ADDU:   ALU_result = rs_content + rt_content;
          FN_SUB, FN_SUBU:   ALU_result = rs_content - rt_content;
          FN_AND:            ALU_result = rs_content & rt_content;
          FN_OR:             ALU_result = rs_content | rt_content;
          FN_XOR:            ALU_result = rs_content ^ rt_content;
          FN_NOR:            ALU_result = ~(rs_content | rt_content);
          FN_SLT:            ALU_result = {31'h0, $signed(rs_content) < $signed(rt_content)};
          FN_SLTU:           ALU_result = {31'h0, rs_content < rt_content};
          default:           ALU_result = 32'h0;
        endcase
      end
      OP_BEQ: begin
        ALU_result = rs_content - rt_content;
        sig_branch = (rs_content == rt_content);
      end
      OP_BNE: begin
        ALU_result = rs_content - rt_content;
        sig_branch = (rs_content != rt_content);
      end
      OP_BLEZ:             sig_branch = $signed(rs_content) <= 0;
      OP_BGTZ:             sig_branch = $signed(rs_content) > 0;
      OP_ADDI, OP_ADDIU:   ALU_result = rs_content + imm_sext;
      OP_SLTI:             ALU_result = {31'h0, $signed(rs_content) < $signed(imm_sext)};
      OP_SLTIU:            ALU_result = {31'h0, rs_content < imm_sext};
      OP_ANDI:             ALU_result = rs_content & imm_zext;
      OP_ORI:              ALU_result = rs_content | imm_zext;
      OP_XORI:             ALU_result = rs_content ^ imm_zext;
      OP_LUI:              ALU_result = {immediate, 16'h0};
      default: begin
        if (opcode >= OP_MEM_LO && opcode <= OP_MEM_HI) begin
          ALU_result = rs_content + imm_sext;
        end
      end
    endcase
  end

  // HI/LO write decode; a divide by zero leaves both registers untouched
  always_comb begin
    hi_we   = 1'b0;
    lo_we   = 1'b0;
    hi_next = hi_reg;
    lo_next = lo_reg;
    if (opcode == OP_RTYPE) begin
      case (functcode)
        FN_MULT, FN_MULTU: begin
          hi_we   = 1'b1;
          lo_we   = 1'b1;
          hi_next = md_product[63:32];
          lo_next = md_product[31:0];
        end
        FN_DIV, FN_DIVU: begin
          hi_we   = !md_div_by_zero;
          lo_we   = !md_div_by_zero;
          hi_next = md_remainder;
          lo_next = md_quotient;
        end
        FN_MTHI: begin
          hi_we   = 1'b1;
          hi_next = rs_content;
        end
        FN_MTLO: begin
          lo_we   = 1'b1;
          lo_next = rs_content;
        end
        default: begin
          hi_we = 1'b0;
          lo_we = 1'b0;
        end
      endcase
    end
  end

  // HI/LO registers, cleared asynchronously by rst_n
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi_reg <= 32'h0;
      lo_reg <= 32'h0;
    end else begin
      if (hi_we) hi_reg <= hi_next;
      if (lo_we) lo_reg <= lo_next;
    end
  end

  assign HI = hi_reg;
  assign LO = lo_reg;

endmodule

// File: tb/tb_alu_2.sv
// Self-checking bench for alu_2: directed cases from the instruction-set
// rules, then randomized instructions against a behavioural model.
module tb_alu_2;

  logic        clk;
  logic        rst_n;
  logic [5:0]  opcode;
  logic [5:0]  functcode;
  logic [4:0]  shamt;
  logic [15:0] immediate;
  logic [31:0] rs_content;
  logic [31:0] rt_content;
  logic [31:0] ALU_result;
  logic        sig_branch;
  logic [31:0] HI;
  logic [31:0] LO;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference architectural state
  logic [31:0] m_hi;
  logic [31:0] m_lo;
  logic [31:0] last_result;
  logic        last_branch;

  alu_2 dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .opcode     (opcode),
    .functcode  (functcode),
    .shamt      (shamt),
    .immediate  (immediate),
    .rs_content (rs_content),
    .rt_content (rt_content),
    .ALU_result (ALU_result),
    .sig_branch (sig_branch),
    .HI         (HI),
    .LO         (LO)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Expected combinational result/branch, straight from the instruction rules
  task automatic model_comb(input logic [5:0] op, input logic [5:0] fn, input logic [4:0] sh,
                            input logic [15:0] imm, input logic [31:0] rs, input logic [31:0] rt,
                            output logic [31:0] res, output logic br);
    longint      srs, srt, simm;
    logic [31:0] sext;
    int          amt;
    srs  = longint'($signed(rs));
    srt  = longint'($signed(rt));
    simm = longint'($signed(imm));
    sext = 32'(simm);
    res  = 32'h0;
    br   = 1'b0;
    if (op == 6'h00) begin
      amt = (fn == 6'h04 || fn == 6'h06 || fn == 6'h07) ? int'(rs % 32) : int'(sh);
      case (fn)
        6'h00, 6'h04: res = 32'(64'(rt) * (64'd1 << amt));
        6'h02, 6'h06: res = 32'(64'(rt) / (64'd1 << amt));
        6'h03, 6'h07: res = 32'(srt >>> amt);
        6'h08, 6'h09: res = rs;
        6'h10:        res = m_hi;
        6'h12:        res = m_lo;
        6'h20, 6'h21: res = 32'(srs + srt);
        6'h22, 6'h23: res = 32'(srs - srt);
        6'h24:        res = rs & rt;
        6'h25:        res = rs | rt;
        6'h26:        res = rs ^ rt;
        6'h27:        res = ~(rs | rt);
        6'h2A:        res = (srs < srt) ? 32'd1 : 32'd0;
        6'h2B:        res = (rs < rt) ? 32'd1 : 32'd0;
        default:      res = 32'h0;
      endcase
    end else begin
      case (op)
        6'h04: begin res = 32'(srs - srt); br = (rs == rt); end
        6'h05: begin res = 32'(srs - srt); br = (rs != rt); end
        6'h06: br = (srs <= 0);
        6'h07: br = (srs > 0);
        6'h08, 6'h09: res = 32'(srs + simm);
        6'h0A: res = (srs < simm) ? 32'd1 : 32'd0;
        6'h0B: res = (rs < sext) ? 32'd1 : 32'd0;
        6'h0C: res = rs & {16'h0, imm};
        6'h0D: res = rs | {16'h0, imm};
        6'h0E: res = rs ^ {16'h0, imm};
        6'h0F: res = {imm, 16'h0};
        default: if (op >= 6'h20 && op <= 6'h2E) res = 32'(srs + simm);
      endcase
    end
  endtask

  // Expected HI/LO after the edge, using 64-bit integer arithmetic
  task automatic model_seq(input logic [5:0] op, input logic [5:0] fn,
                           input logic [31:0] rs, input logic [31:0] rt);
    longint          sp;
    longint unsigned up;
    longint          sq, sr;
    if (op != 6'h00) return;
    case (fn)
      6'h18: begin
        sp = longint'($signed(rs)) * longint'($signed(rt));
        m_hi = 32'(sp >>> 32);
        m_lo = 32'(sp);
      end
      6'h19: begin
        up = longint'(rs) * longint'(rt);
        m_hi = 32'(up >> 32);
        m_lo = 32'(up);
      end
      6'h1A: if (rt != 0) begin
        sq = longint'($signed(rs)) / longint'($signed(rt));
        sr = longint'($signed(rs)) % longint'($signed(rt));
        m_lo = 32'(sq);
        m_hi = 32'(sr);
      end
      6'h1B: if (rt != 0) begin
        m_lo = rs / rt;
        m_hi = rs % rt;
      end
      6'h11: m_hi = rs;
      6'h13: m_lo = rs;
      default: ;
    endcase
  endtask

  // One instruction: drive at posedge+1, check comb outputs, cross the edge, check HI/LO
  task automatic apply(input logic [5:0] op, input logic [5:0] fn, input logic [4:0] sh,
                       input logic [15:0] imm, input logic [31:0] rs, input logic [31:0] rt);
    logic [31:0] er;
    logic        eb;
    opcode = op; functcode = fn; shamt = sh; immediate = imm;
    rs_content = rs; rt_content = rt;
    #2;
    model_comb(op, fn, sh, imm, rs, rt, er, eb);
    last_result = ALU_result;
    last_branch = sig_branch;
    check($sformatf("result op=%0h fn=%0h", op, fn), 64'(ALU_result), 64'(er));
    check($sformatf("branch op=%0h", op), 64'(sig_branch), 64'(eb));
    check("hi_pre_edge", 64'(HI), 64'(m_hi));
    check("lo_pre_edge", 64'(LO), 64'(m_lo));
    @(posedge clk);
    model_seq(op, fn, rs, rt);
    #1;
    check($sformatf("hi op=%0h fn=%0h", op, fn), 64'(HI), 64'(m_hi));
    check($sformatf("lo op=%0h fn=%0h", op, fn), 64'(LO), 64'(m_lo));
  endtask

  logic [5:0]  valid_fn [26] = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h08, 6'h09,
                                 6'h10, 6'h11, 6'h12, 6'h13, 6'h18, 6'h19, 6'h1A, 6'h1B,
                                 6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
                                 6'h2A, 6'h2B};
  logic [31:0] corner [8] = '{32'h0, 32'h1, 32'hFFFFFFFF, 32'h80000000,
                              32'h7FFFFFFF, 32'h00000005, 32'hFFFFFFF9, 32'h0088888A};

  function automatic logic [31:0] rand_operand();
    if ($urandom_range(0, 3) == 0) return corner[$urandom_range(0, 7)];
    return $urandom();
  endfunction

  initial begin
    rst_n = 1'b0;
    opcode = '0; functcode = '0; shamt = '0; immediate = '0;
    rs_content = '0; rt_content = '0;
    m_hi = '0; m_lo = '0;
    #12;
    check("reset_hi", 64'(HI), 64'h0);
    check("reset_lo", 64'(LO), 64'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Multiply / divide
    apply(6'h00, 6'h18, 5'd0, 16'h0, 32'hFFFFFFFC, 32'hFFFFFFFB);
    check("mult_hi", 64'(HI), 64'h00000000);
    check("mult_lo", 64'(LO), 64'h00000014);
    apply(6'h00, 6'h19, 5'd0, 16'h0, 32'h0088888A, 32'h0088888B);
    check("multu_hi", 64'(HI), 64'h000048D1);
    check("multu_lo", 64'(LO), 64'h5BFB72EE);
    apply(6'h00, 6'h1A, 5'd0, 16'h0, 32'hFFFFFFF9, 32'h00000005);
    check("div_hi", 64'(HI), 64'hFFFFFFFE);
    check("div_lo", 64'(LO), 64'hFFFFFFFF);
    apply(6'h00, 6'h1B, 5'd0, 16'h0, 32'h0088888A, 32'h0008888B);
    check("divu_hi", 64'(HI), 64'h00088865);
    check("divu_lo", 64'(LO), 64'h0000000F);
    apply(6'h00, 6'h1A, 5'd0, 16'h0, 32'h12345678, 32'h0);
    check("div0_hi", 64'(HI), 64'h00088865);
    check("div0_lo", 64'(LO), 64'h0000000F);
    apply(6'h00, 6'h1A, 5'd0, 16'h0, 32'h80000000, 32'hFFFFFFFF);
    check("divovf_hi", 64'(HI), 64'h0);
    check("divovf_lo", 64'(LO), 64'h80000000);

    // Shifts and compares
    apply(6'h00, 6'h03, 5'd4, 16'h0, 32'h0, 32'hCA000000);
    check("sra", 64'(last_result), 64'hFCA00000);
    apply(6'h00, 6'h02, 5'd4, 16'h0, 32'h0, 32'h0000004A);
    check("srl", 64'(last_result), 64'h4);
    apply(6'h00, 6'h2B, 5'd0, 16'h0, 32'h0088888A, 32'h0088888B);
    check("sltu", 64'(last_result), 64'h1);
    apply(6'h00, 6'h2A, 5'd0, 16'h0, 32'hFFFFFFFC, 32'h00000014);
    check("slt", 64'(last_result), 64'h1);

    // Branches
    apply(6'h04, 6'h00, 5'd0, 16'h0, 32'h0088888A, 32'h0088888A);
    check("beq_res", 64'(last_result), 64'h0);
    check("beq_br", 64'(last_branch), 64'h1);
    apply(6'h05, 6'h00, 5'd0, 16'h0, 32'h0088888A, 32'h0088888A);
    check("bne_eq_br", 64'(last_branch), 64'h0);
    apply(6'h05, 6'h00, 5'd0, 16'h0, 32'h0088888A, 32'h0088888B);
    check("bne_ne_br", 64'(last_branch), 64'h1);

    // Immediates
    apply(6'h0F, 6'h00, 5'd0, 16'h888A, 32'h0, 32'h0);
    check("lui", 64'(last_result), 64'h888A0000);
    apply(6'h23, 6'h00, 5'd0, 16'h0008, 32'h0000888A, 32'h0);
    check("lw_pos", 64'(last_result), 64'h00008892);
    apply(6'h23, 6'h00, 5'd0, 16'hFFFC, 32'h0000888A, 32'h0);
    check("lw_neg", 64'(last_result), 64'h00008886);

    // HI/LO hazard: MTHI commits only at the edge; MFHI then sees it
    apply(6'h00, 6'h11, 5'd0, 16'h0, 32'h00001234, 32'h0);
    apply(6'h00, 6'h10, 5'd0, 16'h0, 32'h0, 32'h0);
    check("mfhi_after", 64'(last_result), 64'h00001234);

    // Asynchronous reset in mid-cycle
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_hi", 64'(HI), 64'h0);
    check("async_rst_lo", 64'(LO), 64'h0);
    m_hi = '0; m_lo = '0;
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Randomized instruction mix
    for (int i = 0; i < 600; i++) begin
      logic [5:0] op, fn;
      logic [31:0] rs, rt;
      case ($urandom_range(0, 3))
        0, 1: begin
          op = 6'h00;
          fn = ($urandom_range(0, 9) == 0) ? 6'($urandom()) : valid_fn[$urandom_range(0, 25)];
        end
        2:       begin op = 6'($urandom_range(4, 15)); fn = 6'($urandom()); end
        default: begin op = 6'($urandom()); fn = 6'($urandom()); end
      endcase
      rs = rand_operand();
      rt = ($urandom_range(0, 9) == 0) ? 32'h0 : rand_operand();
      if ($urandom_range(0, 7) == 0) rt = rs;
      apply(op, fn, 5'($urandom()), 16'($urandom()), rs, rt);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
